// File: rtl/soc_clkgen_pkg.sv
// Shared FSM state type, default field width and divide arithmetic helpers
// for the soc_system_clkgen_multi clock-enable generator.
package soc_clkgen_pkg;

  localparam int CLKGEN_DIV_W = 8;

  typedef enum logic [1:0] {
    LOCKING = 2'd0,
    RUN     = 2'd1,
    UPDATE  = 2'd2
  } clkgen_state_t;

  function automatic int unsigned eff_div(input int unsigned div);
    return (div == 32'd0) ? 32'd1 : div;
  endfunction

  function automatic int unsigned clamp_phase(input int unsigned phase, input int unsigned d);
    return (phase >= d) ? d - 32'd1 : phase;
  endfunction

  function automatic int unsigned ceil_half(input int unsigned d);
    return (d + 32'd1) / 32'd2;
  endfunction

endpackage

// File: rtl/soc_clkgen_chan.sv
// One divider channel: shadow divide/phase (and duty with SOC_CLKGEN_DUTY_EN),
// a wrapping counter and registered square-wave / enable decode.
module soc_clkgen_chan
  import soc_clkgen_pkg::*;
#(
  parameter int DIV_W       = CLKGEN_DIV_W,
  parameter int DEFAULT_DIV = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic             start,
  input  logic             load,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [DIV_W-1:0] cfg_phase,
`ifdef SOC_CLKGEN_DUTY_EN
  input  logic [DIV_W-1:0] cfg_duty,
`endif
  output logic             outclk,
  output logic             outclk_en
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] phase_q;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_next;
  logic [DIV_W-1:0] d;
  logic [DIV_W-1:0] p;
  logic [DIV_W-1:0] high;
  logic             outclk_next;
  logic             en_next;

  assign d = DIV_W'(eff_div(32'(div_q)));
  assign p = DIV_W'(clamp_phase(32'(phase_q), 32'(d)));

`ifdef SOC_CLKGEN_DUTY_EN
  logic [DIV_W-1:0] duty_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q <= DIV_W'(ceil_half(32'(DEFAULT_DIV)));
    end else if (load) begin
      duty_q <= cfg_duty;
    end
  end

  assign high = duty_q;
`else
  assign high = DIV_W'(ceil_half(32'(d)));
`endif

  // Held and released channels sit at their phase, so the release edge starts every channel together.
  always_comb begin
    cnt_next = p;
    if (!hold && !start) begin
      cnt_next = (cnt_q >= d - 1'b1) ? '0 : cnt_q + 1'b1;
    end
  end

  assign en_next     = (cnt_next == d - 1'b1);
  assign outclk_next = (cnt_next < high);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= DIV_W'(DEFAULT_DIV);
      phase_q   <= '0;
      cnt_q     <= '0;
      outclk    <= 1'b0;
      outclk_en <= 1'b0;
    end else begin
      if (load) begin
        div_q   <= cfg_div;
        phase_q <= cfg_phase;
      end
      cnt_q     <= cnt_next;
      outclk    <= !hold && outclk_next;
      outclk_en <= !hold && en_next;
    end
  end

endmodule

// File: rtl/soc_system_clkgen_multi.sv
// Multi-channel clock-enable generator with config handshake and lock sequencer.
// Optional per-channel duty control is built when SOC_CLKGEN_DUTY_EN is defined.
module soc_system_clkgen_multi
  import soc_clkgen_pkg::*;
#(
  parameter int NUM_CLOCKS  = 3,
  parameter int DIV_W       = CLKGEN_DIV_W,
  parameter int DEFAULT_DIV = 5,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [2:0]            cfg_chan,
  input  logic [DIV_W-1:0]      cfg_div,
  input  logic [DIV_W-1:0]      cfg_phase,
  input  logic [DIV_W-1:0]      cfg_duty,
  output logic                  cfg_err,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic [NUM_CLOCKS-1:0] outclk_en,
  output logic                  locked
);

  localparam int LCW = $clog2(LOCK_CYCLES + 1);

  clkgen_state_t   state_q;
  clkgen_state_t   state_next;
  logic [LCW-1:0]  lock_cnt_q;
  logic [LCW-1:0]  lock_cnt_next;
  logic            locked_next;
  logic            ready_next;
  logic            err_next;
  logic            accept;
  logic            chan_ok;
  logic            lock_done;
  logic            hold;
  logic            start;
  logic [NUM_CLOCKS-1:0] load;

  logic [2:0]       pend_chan_q;
  logic [DIV_W-1:0] pend_div_q;
  logic [DIV_W-1:0] pend_phase_q;

  assign accept    = (state_q == RUN) && cfg_valid && cfg_ready;
  assign chan_ok   = (int'(cfg_chan) < NUM_CLOCKS);
  assign lock_done = (state_q == LOCKING) && (lock_cnt_q == LCW'(LOCK_CYCLES - 1));

  // A valid write silences the outputs on its accept edge; a bad channel never disturbs them.
  assign start = lock_done;
  assign hold  = ((state_q != RUN) || (accept && chan_ok)) && !lock_done;

  always_comb begin
    state_next    = state_q;
    lock_cnt_next = lock_cnt_q;
    locked_next   = locked;
    ready_next    = cfg_ready;
    err_next      = 1'b0;
    case (state_q)
      LOCKING: begin
        lock_cnt_next = lock_cnt_q + 1'b1;
        if (lock_done) begin
          state_next  = RUN;
          locked_next = 1'b1;
          ready_next  = 1'b1;
        end
      end
      RUN: begin
        ready_next = 1'b1;
        if (accept) begin
          ready_next = 1'b0;
          if (chan_ok) begin
            state_next  = UPDATE;
            locked_next = 1'b0;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      UPDATE: begin
        lock_cnt_next = '0;
        state_next    = LOCKING;
      end
      default: begin
        state_next = LOCKING;
      end
    endcase
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LOCKING;
      lock_cnt_q <= '0;
      locked     <= 1'b0;
      cfg_ready  <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      state_q    <= state_next;
      lock_cnt_q <= lock_cnt_next;
      locked     <= locked_next;
      cfg_ready  <= ready_next;
      cfg_err    <= err_next;
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      pend_chan_q  <= '0;
      pend_div_q   <= '0;
      pend_phase_q <= '0;
    end else if (accept && chan_ok) begin
      pend_chan_q  <= cfg_chan;
      pend_div_q   <= cfg_div;
      pend_phase_q <= cfg_phase;
    end
  end

`ifdef SOC_CLKGEN_DUTY_EN
  logic [DIV_W-1:0] pend_duty_q;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      pend_duty_q <= '0;
    end else if (accept && chan_ok) begin
      pend_duty_q <= cfg_duty;
    end
  end
`else
  logic unused_duty;
  assign unused_duty = ^cfg_duty;
`endif

  for (genvar i = 0; i < NUM_CLOCKS; i++) begin : g_chan
    assign load[i] = (state_q == UPDATE) && (pend_chan_q == 3'(i));

    soc_clkgen_chan #(
      .DIV_W      (DIV_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_chan (
      .clk      (refclk),
      .rst_n    (rst_n),
      .hold     (hold),
      .start    (start),
      .load     (load[i]),
      .cfg_div  (pend_div_q),
      .cfg_phase(pend_phase_q),
`ifdef SOC_CLKGEN_DUTY_EN
      .cfg_duty (pend_duty_q),
`endif
      .outclk   (outclk[i]),
      .outclk_en(outclk_en[i])
    );
  end

endmodule
